// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the FIFO read-side streamer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_rd_stream_pkg;

  // Reader FSM: WAIT while the FIFO read side is in reset,
  // RUN while streaming, FLUSH while discarded reads drain.
  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  // Width of the optional statistics counters.
  localparam int STAT_W = 32;

  // Skid entries needed to cover every read in flight plus one beat
  // held at the output and one of slack, so that a full-rate stream
  // never runs out of credit.
  function automatic int skid_depth(input int latency);
    return latency + 2;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying the beats popped from the FIFO.
// Latency: n/a (wires only).
// Backpressure: the master holds m_data/m_valid until m_ready is seen.
//   master: drives m_data, m_valid; samples m_ready
//   slave : samples m_data, m_valid; drives m_ready
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_stream_skid_ring.sv
// Circular skid buffer holding beats returned by the FIFO.
// Latency: push visible at the head one cycle later; occ is registered.
// Backpressure: none internally; the caller never pushes into a full ring.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : drop all entries (head jumps to tail); wins over push/pop
//   push/push_dat : write one entry at the tail
//   pop           : retire the head entry
//   occ, head_dat : entry count and head data
module skid_ring #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head <= tail;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_dat;
        tail      <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head_dat = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Reads a standard-mode FIFO and re-presents its words as a valid/ready stream.
// Latency: rd_en in cycle N -> beat in skid at N+READ_LATENCY -> m_valid at N+READ_LATENCY+1.
// Backpressure: reads are credit-limited by skid occupancy plus reads in flight; m_ready is never combinational to rd_en.
//   wr_clk, rst                 : shared FIFO clock, synchronous active-high reset
//   fifo_dout/empty/rd_rst_busy : FIFO read port status and data; fifo_rd_en drives it
//   flush                       : one-cycle pulse dropping buffered and in-flight beats
//   m_stream (master)           : m_data/m_valid/m_ready output stream
//   busy                        : high in WAIT or FLUSH
//   beat_count, stall_count     : stats, built only with FIFO_RD_STREAM_STATS_EN, else 0
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_rst_busy,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  fifo_rd_stream_if.master      m_stream,
  output logic                  busy,
  output logic [STAT_W-1:0]     beat_count,
  output logic [STAT_W-1:0]     stall_count
);

  localparam int SKID_DEPTH = skid_depth(READ_LATENCY);
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  rd_state_e               state;
  logic [READ_LATENCY-1:0] tag_vld;   // one bit per read still in the FIFO pipeline
  logic [READ_LATENCY-1:0] tag_keep;  // cleared when that read's data must be discarded
  logic [7:0]              inflight;
  logic [7:0]              credit_used;
  logic [OCC_W-1:0]        occ;
  logic                    drop;
  logic                    push;
  logic                    pop;

  // flush and a FIFO read-side reset both throw away everything buffered;
  // only meaningful while streaming.
  assign drop = (state == RUN) && (flush || fifo_rd_rst_busy);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 8'(tag_vld[i]);
  end

  assign credit_used = 8'(occ) + inflight;

  assign fifo_rd_en = (state == RUN) && !fifo_empty && !fifo_rd_rst_busy && !flush &&
                      (credit_used < 8'(SKID_DEPTH));

  // Tag pipeline mirrors the FIFO read latency. Discarded tags keep counting
  // as in flight so FLUSH waits until the stale data has actually gone by.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_keep <= '0;
    end else begin
      tag_vld[0]  <= fifo_rd_en;
      tag_keep[0] <= fifo_rd_en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_keep[i] <= tag_keep[i-1] && !drop;
      end
    end
  end

  assign push = tag_keep[READ_LATENCY-1] && !drop;
  assign pop  = m_stream.m_valid && m_stream.m_ready;

  skid_ring #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk      (wr_clk),
    .rst      (rst),
    .clear    (drop),
    .push     (push),
    .push_dat (fifo_dout),
    .pop      (pop),
    .occ      (occ),
    .head_dat (m_stream.m_data)
  );

  assign m_stream.m_valid = (occ != '0);

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state <= WAIT;
      busy  <= 1'b1;
    end else begin
      case (state)
        WAIT: begin
          if (!fifo_rd_rst_busy) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (fifo_rd_rst_busy) begin
            state <= WAIT;
            busy  <= 1'b1;
          end else if (flush) begin
            state <= FLUSH;
            busy  <= 1'b1;
          end
        end
        FLUSH: begin
          if (inflight == 8'd0) begin
            state <= fifo_rd_rst_busy ? WAIT : RUN;
            busy  <= fifo_rd_rst_busy;
          end
        end
        default: begin
          state <= WAIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop) beat_count <= beat_count + STAT_W'(1);
      if (m_stream.m_valid && !m_stream.m_ready) stall_count <= stall_count + STAT_W'(1);
    end
  end
`else
  assign beat_count  = '0;
  assign stall_count = '0;
`endif

  // Simulation-only invariant checks.
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] hold_dat_q;

  always_ff @(posedge wr_clk) begin
    if (rst) hold_q <= 1'b0;
    else     hold_q <= m_stream.m_valid && !m_stream.m_ready;
  end

  always_ff @(posedge wr_clk) hold_dat_q <= m_stream.m_data;

  always_ff @(posedge wr_clk) begin
    if (!rst) begin
      assert (credit_used <= 8'(SKID_DEPTH))
        else $error("invariant: occ+inflight=%0d exceeds skid depth", credit_used);
      assert (!(fifo_rd_en && fifo_empty))
        else $error("invariant: fifo_rd_en asserted while fifo_empty");
      if (hold_q && m_stream.m_valid)
        assert (m_stream.m_data == hold_dat_q)
          else $error("invariant: m_data changed while stalled");
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- lane 0: READ_LATENCY = 1 ----------------
  logic        rd_en0, flush0, rd_rst_busy0, busy0, fifo_empty0;
  logic [31:0] fifo_dout0 = '0;
  logic [31:0] beat0, stall0;
  logic [31:0] mem0 [0:255];
  int          wp0 = 0;
  int          rp0 = 0;
  assign fifo_empty0 = (wp0 == rp0);

  fifo_rd_stream_if #(.DATA_WIDTH(32)) s0 ();

  fifo_rd_stream #(.DATA_WIDTH(32), .READ_LATENCY(1)) dut0 (
    .wr_clk(clk), .rst(rst), .fifo_dout(fifo_dout0), .fifo_empty(fifo_empty0),
    .fifo_rd_rst_busy(rd_rst_busy0), .fifo_rd_en(rd_en0), .flush(flush0),
    .m_stream(s0), .busy(busy0), .beat_count(beat0), .stall_count(stall0)
  );

  always @(posedge clk)
    if (rd_en0 && rp0 != wp0) begin
      fifo_dout0 <= mem0[rp0];
      rp0        <= rp0 + 1;
    end

  // ---------------- lane 1: READ_LATENCY = 2 ----------------
  logic        rd_en1, flush1, rd_rst_busy1, busy1, fifo_empty1;
  logic [31:0] fifo_dout1 = '0;
  logic [31:0] stg1 = '0;
  logic [31:0] beat1, stall1;
  logic [31:0] mem1 [0:1023];
  int          wp1 = 0;
  int          rp1 = 0;
  assign fifo_empty1 = (wp1 == rp1);

  fifo_rd_stream_if #(.DATA_WIDTH(32)) s1 ();

  fifo_rd_stream #(.DATA_WIDTH(32), .READ_LATENCY(2)) dut1 (
    .wr_clk(clk), .rst(rst), .fifo_dout(fifo_dout1), .fifo_empty(fifo_empty1),
    .fifo_rd_rst_busy(rd_rst_busy1), .fifo_rd_en(rd_en1), .flush(flush1),
    .m_stream(s1), .busy(busy1), .beat_count(beat1), .stall_count(stall1)
  );

  always @(posedge clk) begin
    fifo_dout1 <= stg1;
    if (rd_en1 && rp1 != wp1) begin
      stg1 <= mem1[rp1];
      rp1  <= rp1 + 1;
    end
  end

  // ---------------- monitors (sample on the falling edge) ----------------
  logic [31:0] got0 [0:255];
  int          gcyc0 [0:255];
  int          ngot0 = 0, nrd0 = 0, viol0 = 0;
  logic [31:0] got1 [0:1023];
  int          ngot1 = 0, nrd1 = 0, viol1 = 0, max_out1 = 0;

  always @(negedge clk) begin
    if (s0.m_valid && s0.m_ready) begin
      if (ngot0 < 256) begin
        got0[ngot0]  = s0.m_data;
        gcyc0[ngot0] = cyc;
      end
      ngot0 = ngot0 + 1;
    end
    if (rd_en0) nrd0 = nrd0 + 1;
    if (rd_en0 && fifo_empty0) viol0 = viol0 + 1;

    // reads issued minus beats taken = skid occupancy + reads in flight
    if (nrd1 - ngot1 > max_out1) max_out1 = nrd1 - ngot1;
    if (s1.m_valid && s1.m_ready) begin
      if (ngot1 < 1024) got1[ngot1] = s1.m_data;
      ngot1 = ngot1 + 1;
    end
    if (rd_en1) nrd1 = nrd1 + 1;
    if (rd_en1 && fifo_empty1) viol1 = viol1 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] w);
    mem0[wp0] = w;
    wp0 = wp0 + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int t0, base, nrd_base;

  initial begin
    rst          = 1'b1;
    flush0       = 1'b0;
    rd_rst_busy0 = 1'b0;
    s0.m_ready   = 1'b1;
    flush1       = 1'b0;
    rd_rst_busy1 = 1'b0;
    s1.m_ready   = 1'b0;
    for (int i = 0; i < 16; i++) push0(32'(i));

    // ---- reset state (FIFO already non-empty) ----
    repeat (3) step();
    @(negedge clk);
    chk("rst_rd_en", rd_en0, 0);
    chk("rst_m_valid", s0.m_valid, 0);
    chk("rst_m_data", s0.m_data, 0);
    chk("rst_busy", busy0, 1);
    chk("rst_beat", beat0, 0);
    chk("rst_stall", stall0, 0);
    chk("rst_busy_l2", busy1, 1);

    // ---- streaming 0..15 ----
    step();
    rst = 1'b0;
    t0 = cyc; base = ngot0; nrd_base = nrd0;
    step();
    @(negedge clk);
    chk("stream_busy_low", busy0, 0);
    repeat (21) step();
    @(negedge clk);
    chk("stream_count", ngot0 - base, 16);
    chk("stream_reads", nrd0 - nrd_base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("stream_data", got0[base+i], 32'(i));
      chk("stream_cycle", gcyc0[base+i], t0 + 3 + i);
    end

    // ---- back-pressure: 10 words, ready low ----
    step();
    s0.m_ready = 1'b0;
    base = ngot0; nrd_base = nrd0;
    for (int i = 0; i < 10; i++) push0(32'(100 + i));
    repeat (10) step();
    @(negedge clk);
    chk("bp_reads", nrd0 - nrd_base, 3);
    chk("bp_rd_en_low", rd_en0, 0);
    chk("bp_valid", s0.m_valid, 1);
    chk("bp_head", s0.m_data, 100);
    chk("bp_no_pop", ngot0 - base, 0);
    step();
    s0.m_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("bp_count", ngot0 - base, 10);
    for (int i = 0; i < 10; i++) chk("bp_data", got0[base+i], 32'(100 + i));

    // ---- flush with a read in flight ----
    step();
    s0.m_ready = 1'b0;
    base = ngot0;
    for (int i = 0; i < 4; i++) push0(32'(200 + i));
    @(negedge clk);
    chk("fl_rd_a", rd_en0, 1);
    step();
    step();
    @(negedge clk);
    chk("fl_valid_pre", s0.m_valid, 1);
    chk("fl_head_pre", s0.m_data, 200);
    chk("fl_rd_pre", rd_en0, 1);
    step();
    flush0 = 1'b1;
    @(negedge clk);
    chk("fl_rd_blocked", rd_en0, 0);
    step();
    flush0 = 1'b0;
    @(negedge clk);
    chk("fl_valid_low", s0.m_valid, 0);
    chk("fl_busy", busy0, 1);
    step();
    @(negedge clk);
    chk("fl_busy_done", busy0, 0);
    chk("fl_rd_resume", rd_en0, 1);
    step();
    s0.m_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("fl_count", ngot0 - base, 1);
    chk("fl_next_word", got0[base], 203);

    // ---- FIFO read-side reset busy for 5 cycles mid-stream ----
    step();
    base = ngot0;
    for (int i = 0; i < 20; i++) push0(32'(300 + i));
    repeat (4) step();
    rd_rst_busy0 = 1'b1;
    @(negedge clk);
    chk("rb_rd_first", rd_en0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("rb_rd", rd_en0, 0);
      chk("rb_busy", busy0, 1);
      chk("rb_valid", s0.m_valid, 0);
    end
    step();
    rd_rst_busy0 = 1'b0;
    @(negedge clk);
    chk("rb_busy_wait", busy0, 1);
    chk("rb_rd_wait", rd_en0, 0);
    step();
    @(negedge clk);
    chk("rb_busy_run", busy0, 0);
    chk("rb_rd_run", rd_en0, 1);
    repeat (25) step();
    @(negedge clk);
    chk("rb_count", ngot0 - base, 19);
    for (int i = 0; i < 19; i++)
      chk("rb_data", got0[base+i], (i < 3) ? 32'(300 + i) : 32'(301 + i));
    chk("l1_no_empty_read", viol0, 0);

    // ---- READ_LATENCY=2: random ready, 1000 random words ----
    for (int c = 0; c < 6000 && !(wp1 == 1000 && ngot1 >= 1000); c++) begin
      step();
      s1.m_ready = 1'($urandom_range(0, 1));
      if (wp1 < 1000 && $urandom_range(0, 1) == 1) begin
        mem1[wp1] = $urandom;
        wp1 = wp1 + 1;
      end
    end
    step();
    s1.m_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("l2_count", ngot1, 1000);
    chk("l2_credit_bound", 32'(max_out1 <= 4), 1);
    chk("l2_no_empty_read", viol1, 0);
    for (int i = 0; i < 1000; i++) chk("l2_data", got1[i], mem1[i]);

`ifdef FIFO_RD_STREAM_STATS_EN
    // ---- statistics: 20 pops, 7 stall cycles ----
    step();
    rst = 1'b1;
    s0.m_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) push0(32'(400 + i));
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (!s0.m_valid && w < 20) begin
        @(negedge clk);
        w = w + 1;
      end
    end
    chk("st_valid_seen", s0.m_valid, 1);
    repeat (6) begin
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s0.m_ready = 1'b1;
    repeat (30) step();
    @(negedge clk);
    chk("st_beats", beat0, 20);
    chk("st_stalls", stall0, 7);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("st_beats_rst", beat0, 0);
    chk("st_stalls_rst", stall0, 0);
    rst = 1'b0;
`else
    chk("st_beats_tied", beat0, 0);
    chk("st_stalls_tied", stall0, 0);
    chk("st_beats_tied_l2", beat1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the team's synchronous XPM FIFO wrapper in standard read mode, the reader paired with the FIFO's write-side producer. Drives the FIFO `rd_en`, absorbs the fixed read latency in a small skid buffer, and presents a valid/ready stream to downstream logic. Never underflows the FIFO and sustains one beat per cycle once primed. Sits directly on the FIFO read port, in the same clock domain as the FIFO.

## Interface
- `DATA_WIDTH`, 32, FIFO `dout` width and stream data width.
- `READ_LATENCY`, 1, FIFO read latency in cycles (legal 1..2). Must match the FIFO instance.
- `SKID_DEPTH`, `READ_LATENCY+2`, skid buffer entries. Derived; do not override.

Ports:
- `wr_clk`  in  1  Single clock, shared with the FIFO.
- `rst`  in  1  Synchronous, active-high reset.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_rst_busy`  in  1  FIFO read-side reset busy.
- `fifo_rd_en`  out  1  FIFO read enable.
- `flush`  in  1  Single-cycle pulse. Discards buffered and in-flight beats.
- `m_data`  out  DATA_WIDTH  Stream data.
- `m_valid`  out  1  Stream valid.
- `m_ready`  in  1  Stream ready.
- `busy`  out  1  High in WAIT or FLUSH.
- `beat_count`  out  32  Accepted-beat counter. Present only with the stats macro; otherwise tied to 0.
- `stall_count`  out  32  Count of cycles with `m_valid && !m_ready`. Present only with the stats macro; otherwise tied to 0.

## Operation
**State machine:**
- WAIT
  - Entered on reset.
  - Moves to RUN on the first cycle `fifo_rd_rst_busy` is low.
- RUN
  - Normal operation.
  - Goes to WAIT if `fifo_rd_rst_busy` rises.
  - Goes to FLUSH on `flush`.
- FLUSH
  - Holds until the in-flight count reaches 0, then returns to RUN, or to WAIT if busy.

**Read issue:**
- `fifo_rd_en = (state==RUN) && !fifo_empty && !fifo_rd_rst_busy && !flush && (occ + inflight < SKID_DEPTH)`.
- `occ` and `inflight` are registered. `m_ready` never feeds `fifo_rd_en` combinationally.

**In-flight tracking:**
- A READ_LATENCY-deep valid shift register tags each issued read.
- When a tag exits the shift register, `fifo_dout` is written at the skid tail.
- `inflight` = popcount of the shift register.

**Skid buffer:**
- Circular buffer with SKID_DEPTH entries.
- Head and tail pointers wrap modulo SKID_DEPTH. `occ` is $clog2(SKID_DEPTH+1) bits wide.

**Output and pop:**
- `m_valid = occ != 0`; `m_data` = head entry.
- A pop occurs when `m_valid && m_ready`.
- A simultaneous push and pop leaves `occ` unchanged.

**Flush:**
- `occ` clears next cycle and the head is set to the tail.
- In-flight tags are marked discard; their returning data is dropped.
- No new reads issue until state RUN.
- `flush` in WAIT is a no-op.

**Busy during RUN:**
- If `fifo_rd_rst_busy` rises in RUN, the buffer and in-flight tags are dropped, as in flush.

**Invariants (assert in simulation):**
- `occ + inflight <= SKID_DEPTH`.
- No `fifo_rd_en` while `fifo_empty`.
- `m_data` stable while `m_valid && !m_ready`.

## Timing
**Reset values:**
- `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `busy`=1.
- Counters 0, state WAIT.

**Latency:**
- `fifo_rd_en` at cycle N puts the beat in the skid at N+READ_LATENCY.
- `m_valid` is high at N+READ_LATENCY+1.
- Empty-to-first-valid: READ_LATENCY+2 cycles after `fifo_empty` falls, counting the RUN state registration.

**Throughput:** with `m_ready` held high and FIFO non-empty, one beat per cycle in steady state.

**Back-pressure:** with `m_ready` low, at most SKID_DEPTH beats are accepted from the FIFO, then `fifo_rd_en` stays low.

**Reset mid-operation:** all state clears in the same edge. Returning data from pre-reset reads is ignored because the tags are cleared.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined:
  - `beat_count` increments per pop.
  - `stall_count` increments per cycle with `m_valid && !m_ready`.
  - Both wrap at 2^32 and clear on `rst`; neither clears on `flush`.
- Undefined: counters are not instantiated and both outputs are constant 0.
- The data path is identical either way.

## Structure
Package `fifo_rd_stream_pkg` holds:
- the state enum `rd_state_e` (WAIT, RUN, FLUSH);
- function `skid_depth(latency)`;
- the counter width constant `STAT_W=32`.

The skid buffer is one sub-module, `skid_ring`, with push/pop/clear, parameterised by width and depth, exposing `occ` and the head data. The FSM, tag pipeline and credit logic stay in the top module.

## Test plan
- **Streaming:** reset, FIFO preloaded with 0..15, `m_ready`=1 → `busy` low within 2 cycles; 16 beats 0..15 in order on consecutive cycles after priming; zero `fifo_rd_en` while `fifo_empty`.
- **Back-pressure:** `m_ready`=0 with 10 words queued → exactly SKID_DEPTH (3 at READ_LATENCY=1) reads issued, then `fifo_rd_en` low. Releasing `m_ready` → all 10 beats emitted in order, none lost or duplicated.
- **Flush with reads in flight:** pulse `flush` the cycle after `fifo_rd_en` → `m_valid` low next cycle, returned word dropped, state FLUSH for one cycle, then streaming resumes with the next FIFO word.
- **FIFO reset busy:** `fifo_rd_rst_busy` held high for 5 cycles mid-stream → `fifo_rd_en` low throughout, `busy`=1, buffer cleared; resumes once it falls.
- **READ_LATENCY=2:** random `m_ready` (50%), 1000 random words → scoreboard match, and `occ+inflight<=4` always.
- **Stats (macro defined):** 20 pops and 7 stall cycles → `beat_count`=20, `stall_count`=7. Assert `rst` → both 0 next cycle.
